fifo_sync_param: RTL and testbench

Parametrised single-clock synchronous FIFO, the successor of the fixed 4×16 FIFO. Generalised in data width and depth; adds an occupancy count, programmable almost-full/almost-empty flags, and defined behaviour for simultaneous read/write at full and at empty. Sits between producer and consumer datapaths in one clock domain. Optional sticky overflow/underflow error flags are compiled in by macro.

---
 rtl/fifo_defs_pkg.sv | 31 +++
 rtl/fifo_sync_mem.sv | 57 +++++
 rtl/fifo_sync_param.sv | 150 +++++++++++++++
 tb/tb_fifo_sync_param.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_defs_pkg.sv
// -----------------------------------------------------------------------------
// fifo_defs : shared definitions for the parametrised synchronous FIFO.
//
// Contents:
//   DEF_WIDTH / DEF_DEPTH : default data width and depth.
//   ERR_FLAG_EN           : 1 when the build defines FIFO_ERR_FLAG_EN, which
//                           compiles in the sticky overflow/underflow flags.
//   clog2()               : ceiling log2, used for pointer widths.
// -----------------------------------------------------------------------------
package fifo_defs;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

`ifdef FIFO_ERR_FLAG_EN
  localparam bit ERR_FLAG_EN = 1'b1;
`else
  localparam bit ERR_FLAG_EN = 1'b0;
`endif

  // Smallest r with (1 << r) >= value; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// -----------------------------------------------------------------------------
// fifo_sync_mem : simple dual-port storage for fifo_sync_param.
//
// One write port and one registered read port on a single clock. The storage
// array itself is never reset so it maps onto block/distributed RAM; only the
// read-data register is cleared by rstn so the FIFO output starts at zero.
//
// Ports:
//   clk      in   rising-edge clock
//   rstn     in   asynchronous active-low reset (read register only)
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe; rd_data updates only when high
//   rd_addr  in   read address
//   rd_data  out  registered read data, holds when rd_en is low
// -----------------------------------------------------------------------------
module fifo_sync_mem
  import fifo_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [WIDTH-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  // The controller never reads and writes the same slot in one cycle
  // (that only happens at empty or full, where one side is rejected), so
  // no read-during-write bypass is needed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem_reg[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/fifo_sync_param.sv
// -----------------------------------------------------------------------------
// fifo_sync_param : parametrised single-clock synchronous FIFO.
//
// Holds the head/tail pointers, occupancy count, status flags and optional
// sticky error flags; storage lives in fifo_sync_mem.
// Build macro: FIFO_ERR_FLAG_EN adds errclrp/ovfp/udfp.
//
// Ports:
//   clk           in   rising-edge clock
//   rstn          in   asynchronous active-low reset
//   din           in   write data
//   writep        in   write request (accepted when not full)
//   readp         in   read request (accepted when not empty)
//   dout          out  registered read data, valid 1 cycle after accepted read
//   emptyp        out  count == 0
//   fullp         out  count == DEPTH
//   almostemptyp  out  count <= AE_LEVEL
//   almostfullp   out  count >= AF_LEVEL
//   count         out  occupancy 0..DEPTH
//   errclrp       in   clears sticky error flags      (FIFO_ERR_FLAG_EN)
//   ovfp          out  sticky: write while full       (FIFO_ERR_FLAG_EN)
//   udfp          out  sticky: read while empty       (FIFO_ERR_FLAG_EN)
// -----------------------------------------------------------------------------
module fifo_sync_param
  import fifo_defs::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int ADDR_W  = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [WIDTH-1:0]  din,
  input  logic              writep,
  input  logic              readp,
  output logic [WIDTH-1:0]  dout,
  output logic              emptyp,
  output logic              fullp,
  output logic              almostemptyp,
  output logic              almostfullp,
  output logic [ADDR_W:0]   count
`ifdef FIFO_ERR_FLAG_EN
  ,
  input  logic              errclrp,
  output logic              ovfp,
  output logic              udfp
`endif
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_CNT   = (ADDR_W + 1)'(AE_LEVEL);

  logic [ADDR_W-1:0] head_reg, head_next;
  logic [ADDR_W-1:0] tail_reg, tail_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              wr_ok, rd_ok;

  // Acceptance uses the registered flags, so readp/writep never reach the
  // flag outputs combinationally.
  assign wr_ok = writep & ~fullp;
  assign rd_ok = readp & ~emptyp;

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    // Pointers wrap naturally at ADDR_W bits since DEPTH is a power of two.
    if (wr_ok) begin
      head_next = head_reg + 1'b1;
    end
    if (rd_ok) begin
      tail_next = tail_reg + 1'b1;
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  assign count        = count_reg;
  assign emptyp       = (count_reg == '0);
  assign fullp        = (count_reg == FULL_CNT);
  assign almostemptyp = (count_reg <= AE_CNT);
  assign almostfullp  = (count_reg >= AF_CNT);

  fifo_sync_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_ok),
    .wr_addr (head_reg),
    .wr_data (din),
    .rd_en   (rd_ok),
    .rd_addr (tail_reg),
    .rd_data (dout)
  );

`ifdef FIFO_ERR_FLAG_EN
  logic ovf_reg, ovf_next;
  logic udf_reg, udf_next;

  // Clear is applied first so a same-cycle set overrides it.
  always_comb begin
    ovf_next = ovf_reg;
    udf_next = udf_reg;
    if (errclrp) begin
      ovf_next = 1'b0;
      udf_next = 1'b0;
    end
    if (writep & fullp) begin
      ovf_next = 1'b1;
    end
    if (readp & emptyp) begin
      udf_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_reg <= 1'b0;
      udf_reg <= 1'b0;
    end else begin
      ovf_reg <= ovf_next;
      udf_reg <= udf_next;
    end
  end

  assign ovfp = ovf_reg;
  assign udfp = udf_reg;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_param : scoreboard bench for fifo_sync_param (WIDTH=16, DEPTH=8,
// AF_LEVEL=6, AE_LEVEL=2). Stimulus is driven on the falling edge; a queue
// model predicts the post-edge state and pushes it to the scoreboard. The
// monitor pops one record 1 time unit after every rising edge and compares.
// Define FIFO_ERR_FLAG_EN to also exercise the sticky error flags.
// -----------------------------------------------------------------------------
module tb_fifo_sync_param;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] din = '0;
  logic        writep = 1'b0;
  logic        readp = 1'b0;
  logic [15:0] dout;
  logic        emptyp, fullp, almostemptyp, almostfullp;
  logic [3:0]  count;
`ifdef FIFO_ERR_FLAG_EN
  logic        errclrp = 1'b0;
  logic        ovfp, udfp;
`endif

  fifo_sync_param #(
    .WIDTH    (16),
    .DEPTH    (8),
    .AF_LEVEL (6),
    .AE_LEVEL (2)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .din          (din),
    .writep       (writep),
    .readp        (readp),
    .dout         (dout),
    .emptyp       (emptyp),
    .fullp        (fullp),
    .almostemptyp (almostemptyp),
    .almostfullp  (almostfullp),
    .count        (count)
`ifdef FIFO_ERR_FLAG_EN
    ,
    .errclrp      (errclrp),
    .ovfp         (ovfp),
    .udfp         (udfp)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dout;
    int          cnt;
    bit          empty;
    bit          full;
    bit          ae;
    bit          af;
    bit          ovf;
    bit          udf;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] model_q[$];
  logic [15:0] model_dout = '0;
  bit          model_ovf = 1'b0;
  bit          model_udf = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_txn = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_state();
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_emptyp", 32'(emptyp), 32'd1);
    check("rst_fullp", 32'(fullp), 32'd0);
    check("rst_almostemptyp", 32'(almostemptyp), 32'd1);
    check("rst_almostfullp", 32'(almostfullp), 32'd0);
`ifdef FIFO_ERR_FLAG_EN
    check("rst_ovfp", 32'(ovfp), 32'd0);
    check("rst_udfp", 32'(udfp), 32'd0);
`endif
  endtask

  // Drive one cycle of requests and predict the state after the next edge.
  task automatic step(input bit w, input bit r, input logic [15:0] d, input bit clr = 1'b0);
    exp_t e;
    bit   full_now;
    bit   empty_now;
    @(negedge clk);
    writep = w;
    readp  = r;
    din    = d;
`ifdef FIFO_ERR_FLAG_EN
    errclrp = clr;
`endif
    full_now  = (model_q.size() == 8);
    empty_now = (model_q.size() == 0);
    if (r && !empty_now) model_dout = model_q.pop_front();
    if (w && !full_now) model_q.push_back(d);
    if (clr) begin
      model_ovf = 1'b0;
      model_udf = 1'b0;
    end
    if (w && full_now) model_ovf = 1'b1;
    if (r && empty_now) model_udf = 1'b1;
    e.dout  = model_dout;
    e.cnt   = model_q.size();
    e.empty = (e.cnt == 0);
    e.full  = (e.cnt == 8);
    e.ae    = (e.cnt <= 2);
    e.af    = (e.cnt >= 6);
    e.ovf   = model_ovf;
    e.udf   = model_udf;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) begin
      if (model_q.size() > 0) step(1'b0, 1'b1, 16'h0);
    end
  endtask

  // Monitor: compare the DUT against the oldest prediction after each edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_txn++;
      check("dout", 32'(dout), 32'(mon_e.dout));
      check("count", 32'(count), 32'(mon_e.cnt));
      check("emptyp", 32'(emptyp), 32'(mon_e.empty));
      check("fullp", 32'(fullp), 32'(mon_e.full));
      check("almostemptyp", 32'(almostemptyp), 32'(mon_e.ae));
      check("almostfullp", 32'(almostfullp), 32'(mon_e.af));
`ifdef FIFO_ERR_FLAG_EN
      check("ovfp", 32'(ovfp), 32'(mon_e.ovf));
      check("udfp", 32'(udfp), 32'(mon_e.udf));
`endif
      $display("txn %0d: count=%0d dout=%h exp_count=%0d exp_dout=%h",
               n_txn, count, dout, mon_e.cnt, mon_e.dout);
    end
  end

  initial begin
    // Reset then idle.
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    @(negedge clk);
    rstn = 1'b1;
    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);

    // Fill with 1..8 then read all back in order.
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 16'(i));
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h0);
    step(1'b0, 1'b0, 16'h0);

    // Simultaneous read/write while full: write dropped.
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 16'(i));
    step(1'b1, 1'b1, 16'hBEEF);
    drain();
    step(1'b0, 1'b0, 16'h0);

    // Simultaneous read/write while empty: read dropped.
    step(1'b1, 1'b1, 16'h1234);
    step(1'b0, 1'b1, 16'h0);
    step(1'b0, 1'b0, 16'h0);

    // Steady write+read at count 3 across pointer wrap.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'($urandom));
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 16'($urandom));
    drain();

    // Random traffic: write-biased half, then read-biased half.
    for (int i = 0; i < 400; i++) begin
      if (i < 200)
        step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 40, 16'($urandom));
      else
        step($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 70, 16'($urandom));
    end
    drain();
    step(1'b0, 1'b0, 16'h0);

`ifdef FIFO_ERR_FLAG_EN
    // Sticky error flags.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'($urandom));
    step(1'b1, 1'b0, 16'hDEAD);
    step(1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 16'hDEAD, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    drain();
    step(1'b0, 1'b1, 16'h0);
    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b0, 16'h0);
`endif

    // Asynchronous reset mid-fill discards contents.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'($urandom));
    step(1'b0, 1'b1, 16'h0);
    step(1'b0, 1'b0, 16'h0);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check_reset_state();
    model_q.delete();
    model_dout = '0;
    model_ovf  = 1'b0;
    model_udf  = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    step(1'b0, 1'b1, 16'h0);
    step(1'b1, 1'b0, 16'h00A5);
    step(1'b0, 1'b1, 16'h0);
    step(1'b0, 1'b0, 16'h0);

    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
